multicycle_cont_unit: RTL and testbench
=======================================

# multicycle_cont_unit

Multi-cycle control FSM that sequences the shared datapath (register file, single ALU, unified instruction/data memory) one instruction at a time over 3–5 cycles. It replaces the single-cycle decoder. It sits between the instruction register and the datapath. It produces every enable and mux select per cycle, and keeps the Z flag used by conditional branches.

## Interface
Parameters:
- RETIRE_W, 16, width of retired-instruction counter

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; all state and outputs cleared on the edge it is sampled high
- inst  in  32  instruction register contents
- comp_flag  in  1  ALU zero result from the datapath, same cycle
- mem_ready  in  1  memory access complete (used only with MC_MEM_WAIT_EN)
- PCWrite, IRWrite, MemWrite, RegWrite  out  1 each  datapath write enables
- AdrSrc  out  1  0 = PC, 1 = ALU result register
- AluSrcA  out  1  0 = PC, 1 = RD1
- AluSrcB  out  2  00 = RD2, 01 = Extimm, 10 = constant 4
- AluControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 PASS-B
- ResultSrc  out  2  00 = ALU out register, 01 = data register, 10 = ALU result
- ShiftEn  out  1  route RD2 through the shifter
- state  out  4  current FSM state (debug)
- flag_z  out  1  latched zero flag
- illegal  out  1  one-cycle pulse on an undecodable instruction
- retired  out  RETIRE_W  count of completed instructions

## Operation
- Decode fields:
  - cond inst[31:28]: 1110 = AL, 0000 = EQ; any other value is illegal.
  - op inst[27:26]: 00 = DP, 01 = MEM, 10 = BR.
  - I inst[25]; cmd inst[24:21]; L inst[20].
- DP cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no RegWrite), 1101 MOV (PASS-B, ShiftEn=1 when I=0). Any other cmd is illegal.
- States (encoding in brackets):
  - FETCH[0]: AdrSrc=0, IRWrite=1, AluSrcA=0, AluSrcB=10, ADD, ResultSrc=10, PCWrite=1 → DECODE.
  - DECODE[1]: AluSrcA=0, AluSrcB=10, ADD (PC+8 precompute). Next state by op:
    - MEM → MEMADR
    - DP with I=0 → EXECR
    - DP with I=1 → EXECI
    - BR → BRANCH
    - Illegal → FETCH, with illegal=1.
  - MEMADR[2]: AluSrcA=1, AluSrcB=01, ADD → MEMRD if L=1, else MEMWR.
  - MEMRD[3]: AdrSrc=1 → MEMWB.
  - MEMWB[4]: ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWR[5]: AdrSrc=1, MemWrite=1 → FETCH.
  - EXECR[6]: AluSrcA=1, AluSrcB=00, AluControl per cmd → ALUWB.
  - EXECI[7]: same as EXECR but AluSrcB=01 → ALUWB.
  - ALUWB[8]: ResultSrc=00. RegWrite=1 unless CMP. flag_z ← comp_flag (sampled in the EXEC cycle) for CMP and SUB only → FETCH.
  - BRANCH[9]: AluSrcA=0, AluSrcB=01, ADD, ResultSrc=10. PCWrite=1 if cond=AL, or if cond=EQ and flag_z=1 → FETCH.
- Unused state codes (10–15) → FETCH, with no enables asserted.
- retired increments on every transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH, whether or not the branch is taken. It wraps modulo 2^RETIRE_W. Illegal instructions are not counted.
- At most one of RegWrite/MemWrite is high in any cycle. IRWrite is high only in FETCH.

## Timing
- All outputs are Moore (decoded from state register and inst), except illegal, which is registered and high for the cycle after DECODE.
- Reset:
  - state=FETCH, flag_z=0, retired=0, illegal=0.
  - All enables (PCWrite, IRWrite, MemWrite, RegWrite) are forced to 0 while reset is high.
  - Mux selects are 0.
  - Reset high mid-instruction aborts it at the next edge with no write in that cycle.
- Latency (no waits): DP 4 cycles, LDR 5, STR 4, B/BEQ 3, illegal 2.
- flag_z written in ALUWB is visible to a BRANCH in the immediately following instruction.

## Configuration
- MC_MEM_WAIT_EN defined:
  - FETCH, MEMRD and MEMWR hold their state and outputs until mem_ready=1.
  - PCWrite and IRWrite in FETCH, and MemWrite in MEMWR, are asserted only in the cycle mem_ready=1.
  - MEMRD advances on mem_ready=1.
- MC_MEM_WAIT_EN undefined: mem_ready is ignored; every memory state takes exactly one cycle.

## Test plan
- Reset held for 2 cycles, then ADD R1,R2,R3 (0xE0821003) → states 0,1,6,8,0; RegWrite=1 only in state 8; retired=1.
- LDR 0xE5921004 → states 0,1,2,3,4; ResultSrc=01 with RegWrite in state 4. STR 0xE5821004 → MemWrite=1 only in state 5.
- CMP with comp_flag=1, then BEQ 0x0A000002 → flag_z=1, PCWrite=1 in BRANCH. Repeat with comp_flag=0 → PCWrite=0, retired still increments.
- cond=0x3 instruction → illegal pulses once, next state FETCH, retired unchanged, no RegWrite/MemWrite.
- Reset asserted in MEMWR → MemWrite=0 that cycle; state=0 and all enables 0 after the edge.
- With MC_MEM_WAIT_EN, mem_ready low for 3 cycles in FETCH → state stays 0 with IRWrite=PCWrite=0; both pulse for exactly 1 cycle when mem_ready rises.

Source files
------------

// File: rtl/multicycle_cont_unit.sv
// rtl/multicycle_cont_unit.sv - multi-cycle control FSM for the shared datapath
//
// Sequences one instruction at a time through FETCH, DECODE and 1-3 execute
// states, producing every datapath enable and mux select per cycle.
// Optional build macro: MC_MEM_WAIT_EN (memory states stall on mem_ready).
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   inst                 instruction register contents
//   comp_flag            ALU zero result from the datapath
//   mem_ready            memory access complete (only with MC_MEM_WAIT_EN)
//   PCWrite/IRWrite/MemWrite/RegWrite   datapath write enables
//   AdrSrc, AluSrcA, AluSrcB, AluControl, ResultSrc, ShiftEn   mux selects
//   state                current FSM state (debug)
//   flag_z               latched zero flag used by BEQ
//   illegal              one-cycle pulse after DECODE of a bad instruction
//   retired              completed-instruction counter (wraps)

module multicycle_cont_unit #(
    parameter int RETIRE_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         inst,
    input  logic                comp_flag,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                AdrSrc,
    output logic                AluSrcA,
    output logic [1:0]          AluSrcB,
    output logic [2:0]          AluControl,
    output logic [1:0]          ResultSrc,
    output logic                ShiftEn,
    output logic [3:0]          state,
    output logic                flag_z,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [RETIRE_W-1:0] RET_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       comp_q;
    logic       mem_go;

    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit;
    logic [3:0] cmd;
    logic       l_bit;
    logic       cond_al;
    logic       cond_eq;
    logic [2:0] alu_cmd;
    logic       dp_cmd_ok;
    logic       is_illegal;
    logic       retire_evt;

    assign cond    = inst[31:28];
    assign op      = inst[27:26];
    assign i_bit   = inst[25];
    assign cmd     = inst[24:21];
    assign l_bit   = inst[20];
    assign cond_al = (cond == 4'hE);
    assign cond_eq = (cond == 4'h0);
    assign state   = state_q;

    // Register/immediate fields are consumed by the datapath, not here.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst[19:0];

`ifdef MC_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go = 1'b1;
`endif

    always_comb begin
        alu_cmd   = 3'b000;
        dp_cmd_ok = 1'b1;
        case (cmd)
            CMD_ADD: alu_cmd = 3'b000;
            CMD_SUB: alu_cmd = 3'b001;
            CMD_AND: alu_cmd = 3'b010;
            CMD_ORR: alu_cmd = 3'b011;
            CMD_CMP: alu_cmd = 3'b001;
            CMD_MOV: alu_cmd = 3'b100;
            default: dp_cmd_ok = 1'b0;
        endcase
    end

    assign is_illegal = ~(cond_al | cond_eq) | (op == 2'b11) |
                        ((op == OP_DP) & ~dp_cmd_ok);

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_illegal)         state_d = S_FETCH;
                else if (op == OP_MEM)  state_d = S_MEMADR;
                else if (op == OP_BR)   state_d = S_BRANCH;
                else                    state_d = i_bit ? S_EXECI : S_EXECR;
            end
            S_MEMADR: state_d = l_bit ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_go ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_go ? S_FETCH : S_MEMWR;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // A store only retires once its write has actually been accepted.
    assign retire_evt = (state_q == S_MEMWB) | (state_q == S_ALUWB) |
                        (state_q == S_BRANCH) | ((state_q == S_MEMWR) & mem_go);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            flag_z  <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
            comp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            illegal <= (state_q == S_DECODE) & is_illegal;
            if (retire_evt)
                retired <= retired + RET_ONE;
            // Zero result is captured while the ALU is computing and only
            // committed to flag_z at writeback.
            if (state_q == S_EXECR || state_q == S_EXECI)
                comp_q <= comp_flag;
            if (state_q == S_ALUWB && (cmd == CMD_SUB || cmd == CMD_CMP))
                flag_z <= comp_q;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        AluSrcA    = 1'b0;
        AluSrcB    = 2'b00;
        AluControl = 3'b000;
        ResultSrc  = 2'b00;
        ShiftEn    = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = mem_go;
                PCWrite   = mem_go;
                AluSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: AluSrcB = 2'b10;
            S_MEMADR: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b01;
            end
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = mem_go;
            end
            S_EXECR, S_EXECI: begin
                AluSrcA    = 1'b1;
                AluSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                AluControl = alu_cmd;
                ShiftEn    = (cmd == CMD_MOV) & ~i_bit;
            end
            S_ALUWB: RegWrite = (cmd != CMD_CMP);
            S_BRANCH: begin
                AluSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_al | (cond_eq & flag_z);
            end
            default: ;
        endcase
        // Reset suppresses every write and select in the cycle it is high,
        // so an aborted instruction leaves no side effects.
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            AdrSrc     = 1'b0;
            AluSrcA    = 1'b0;
            AluSrcB    = 2'b00;
            AluControl = 3'b000;
            ResultSrc  = 2'b00;
            ShiftEn    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_cont_unit.sv
// tb/tb_multicycle_cont_unit.sv - self-checking bench for multicycle_cont_unit

module tb_multicycle_cont_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst = 32'h0;
    logic        comp_flag = 1'b0;
    logic        mem_ready = 1'b1;
    logic        PCWrite, IRWrite, MemWrite, RegWrite;
    logic        AdrSrc, AluSrcA, ShiftEn;
    logic [1:0]  AluSrcB, ResultSrc;
    logic [2:0]  AluControl;
    logic [3:0]  state;
    logic        flag_z, illegal;
    logic [15:0] retired;

    multicycle_cont_unit #(.RETIRE_W(16)) dut (
        .clock(clock), .reset(reset), .inst(inst), .comp_flag(comp_flag),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluControl(AluControl),
        .ResultSrc(ResultSrc), .ShiftEn(ShiftEn), .state(state),
        .flag_z(flag_z), .illegal(illegal), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] inst;
        logic        cf;
        logic [31:0] trace;
        int          cyc;
        int          regw;
        int          memw;
        int          pcw;
        logic        ill;
        int          ret;
        logic        fz;
        logic [2:0]  alu;
        logic        sh;
    } vec_t;

    vec_t tbl[17];

    int total = 0;
    int bad = 0;
    int viol = 0;
    int ill_seen = 0;
    int ill_exp = 0;
    logic [15:0] exp_ret = 16'd0;
    logic        fz_model = 1'b0;

    logic [31:0] obs_trace;
    int          obs_cyc, obs_regw, obs_memw, obs_pcw;
    logic [2:0]  obs_alu;
    logic        obs_sh;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Run one instruction starting just after an edge that left the FSM in FETCH.
    task automatic run_inst(input logic [31:0] ins, input logic cf);
        int k;
        inst = ins;
        comp_flag = cf;
        obs_trace = 0; obs_regw = 0; obs_memw = 0; obs_pcw = 0;
        obs_alu = 3'b000; obs_sh = 1'b0;
        k = 0;
        do begin
            @(negedge clock);
            if (k < 8) obs_trace = obs_trace | (32'(state) << (4 * k));
            if (RegWrite) obs_regw++;
            if (MemWrite) obs_memw++;
            if (PCWrite)  obs_pcw++;
            if (illegal)  ill_seen++;
            if (state == 4'd6 || state == 4'd7) begin
                obs_alu = AluControl;
                obs_sh  = ShiftEn;
            end
            if (RegWrite && MemWrite) viol++;
            if (IRWrite && state != 4'd0) viol++;
            if (MemWrite && state != 4'd5) viol++;
            if (RegWrite && !((state == 4'd4 && ResultSrc == 2'b01) ||
                              (state == 4'd8 && ResultSrc == 2'b00))) viol++;
            @(posedge clock); #1;
            k++;
        end while (state != 4'd0 && k < 12);
        obs_cyc = k;
    endtask

    task automatic apply(input string tag, input vec_t v);
        run_inst(v.inst, v.cf);
        exp_ret = exp_ret + 16'(v.ret);
        if (v.ill) ill_exp++;
        chk({tag, "_trace"},   obs_trace,        v.trace);
        chk({tag, "_cycles"},  32'(obs_cyc),     32'(v.cyc));
        chk({tag, "_regw"},    32'(obs_regw),    32'(v.regw));
        chk({tag, "_memw"},    32'(obs_memw),    32'(v.memw));
        chk({tag, "_pcw"},     32'(obs_pcw),     32'(v.pcw));
        chk({tag, "_illegal"}, 32'(illegal),     32'(v.ill));
        chk({tag, "_retired"}, 32'(retired),     32'(exp_ret));
        chk({tag, "_flag_z"},  32'(flag_z),      32'(v.fz));
        chk({tag, "_alu"},     32'(obs_alu),     32'(v.alu));
        chk({tag, "_shift"},   32'(obs_sh),      32'(v.sh));
    endtask

    // Reference: classify the instruction and derive its visible behaviour.
    task automatic model(input logic [31:0] ins, input logic cf, input logic fz_in, output vec_t v);
        logic [3:0] c;
        logic [1:0] op;
        logic       ib, lb, legal_cmd;
        logic [3:0] cm;
        c = ins[31:28]; op = ins[27:26]; ib = ins[25]; cm = ins[24:21]; lb = ins[20];
        legal_cmd = (cm == 4'h4) || (cm == 4'h2) || (cm == 4'h0) ||
                    (cm == 4'hC) || (cm == 4'hA) || (cm == 4'hD);
        v.inst = ins; v.cf = cf;
        v.trace = 32'h10; v.cyc = 2; v.regw = 0; v.memw = 0; v.pcw = 1;
        v.ill = 1'b0; v.ret = 1; v.fz = fz_in; v.alu = 3'b000; v.sh = 1'b0;
        if (!(c == 4'hE || c == 4'h0) || op == 2'b11 || (op == 2'b00 && !legal_cmd)) begin
            v.ill = 1'b1;
            v.ret = 0;
        end else if (op == 2'b00) begin
            v.trace = ib ? 32'h8710 : 32'h8610;
            v.cyc = 4;
            v.regw = (cm == 4'hA) ? 0 : 1;
            case (cm)
                4'h4: v.alu = 3'd0;
                4'h2: v.alu = 3'd1;
                4'h0: v.alu = 3'd2;
                4'hC: v.alu = 3'd3;
                4'hA: v.alu = 3'd1;
                default: v.alu = 3'd4;
            endcase
            v.sh = (cm == 4'hD) && !ib;
            if (cm == 4'h2 || cm == 4'hA) v.fz = cf;
        end else if (op == 2'b01) begin
            if (lb) begin v.trace = 32'h43210; v.cyc = 5; v.regw = 1; end
            else    begin v.trace = 32'h5210;  v.cyc = 4; v.memw = 1; end
        end else begin
            v.trace = 32'h910;
            v.cyc = 3;
            v.pcw = (c == 4'hE || fz_in) ? 2 : 1;
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [3:0] cmds [6];
        logic [3:0] c, cm;
        int r;
        cmds = '{4'h4, 4'h2, 4'h0, 4'hC, 4'hA, 4'hD};
        r = $urandom_range(0, 9);
        c = (r < 6) ? 4'hE : (r < 8) ? 4'h0 : 4'($urandom);
        cm = ($urandom_range(0, 9) < 8) ? cmds[$urandom_range(0, 5)] : 4'($urandom);
        return {c, 2'($urandom_range(0, 3)), 1'($urandom), cm, 1'($urandom), 20'($urandom)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog state=%0d", state);
        $fatal(1);
    end

    initial begin
        vec_t v;
        int k;
        tbl[0]  = '{32'hE0821003, 1'b0, 32'h8610,  4, 1, 0, 1, 1'b0, 1, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{32'hE5921004, 1'b0, 32'h43210, 5, 1, 0, 1, 1'b0, 1, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{32'hE5821004, 1'b0, 32'h5210,  4, 0, 1, 1, 1'b0, 1, 1'b0, 3'd0, 1'b0};
        tbl[3]  = '{32'hE1520003, 1'b1, 32'h8610,  4, 0, 0, 1, 1'b0, 1, 1'b1, 3'd1, 1'b0};
        tbl[4]  = '{32'h0A000002, 1'b0, 32'h910,   3, 0, 0, 2, 1'b0, 1, 1'b1, 3'd0, 1'b0};
        tbl[5]  = '{32'hE1520003, 1'b0, 32'h8610,  4, 0, 0, 1, 1'b0, 1, 1'b0, 3'd1, 1'b0};
        tbl[6]  = '{32'h0A000002, 1'b0, 32'h910,   3, 0, 0, 1, 1'b0, 1, 1'b0, 3'd0, 1'b0};
        tbl[7]  = '{32'h30821003, 1'b0, 32'h10,    2, 0, 0, 1, 1'b1, 0, 1'b0, 3'd0, 1'b0};
        tbl[8]  = '{32'hE2421001, 1'b1, 32'h8710,  4, 1, 0, 1, 1'b0, 1, 1'b1, 3'd1, 1'b0};
        tbl[9]  = '{32'hE1A01002, 1'b0, 32'h8610,  4, 1, 0, 1, 1'b0, 1, 1'b1, 3'd4, 1'b1};
        tbl[10] = '{32'hEA000004, 1'b0, 32'h910,   3, 0, 0, 2, 1'b0, 1, 1'b1, 3'd0, 1'b0};
        tbl[11] = '{32'hE0221003, 1'b0, 32'h10,    2, 0, 0, 1, 1'b1, 0, 1'b1, 3'd0, 1'b0};
        tbl[12] = '{32'hEC000000, 1'b0, 32'h10,    2, 0, 0, 1, 1'b1, 0, 1'b1, 3'd0, 1'b0};
        tbl[13] = '{32'hE0021003, 1'b1, 32'h8610,  4, 1, 0, 1, 1'b0, 1, 1'b1, 3'd2, 1'b0};
        tbl[14] = '{32'hE1821003, 1'b0, 32'h8610,  4, 1, 0, 1, 1'b0, 1, 1'b1, 3'd3, 1'b0};
        tbl[15] = '{32'hE0421003, 1'b0, 32'h8610,  4, 1, 0, 1, 1'b0, 1, 1'b0, 3'd1, 1'b0};
        tbl[16] = '{32'h0A000002, 1'b0, 32'h910,   3, 0, 0, 1, 1'b0, 1, 1'b0, 3'd0, 1'b0};

        // Reset held for two cycles; enables must stay low even in FETCH.
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rst_state",    32'(state),     32'd0);
        chk("rst_irwrite",  32'(IRWrite),   32'd0);
        chk("rst_pcwrite",  32'(PCWrite),   32'd0);
        chk("rst_regwrite", 32'(RegWrite),  32'd0);
        chk("rst_memwrite", 32'(MemWrite),  32'd0);
        chk("rst_alusrcb",  32'(AluSrcB),   32'd0);
        chk("rst_result",   32'(ResultSrc), 32'd0);
        chk("rst_retired",  32'(retired),   32'd0);
        chk("rst_flag_z",   32'(flag_z),    32'd0);
        chk("rst_illegal",  32'(illegal),   32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 17; i++)
            apply($sformatf("vec%0d", i), tbl[i]);
        fz_model = tbl[16].fz;

        for (int i = 0; i < 40; i++) begin
            model(rand_inst(), 1'($urandom), fz_model, v);
            apply($sformatf("rnd%0d", i), v);
            fz_model = v.fz;
        end

        model(32'hE0821003, 1'b0, fz_model, v);
        apply("final_add", v);
        chk("illegal_pulses", 32'(ill_seen), 32'(ill_exp));

        // Reset asserted while a store sits in MEMWR.
        inst = 32'hE5821004;
        k = 0;
        while (state != 4'd5 && k < 8) begin
            @(posedge clock); #1;
            k++;
        end
        chk("reach_memwr", 32'(state), 32'd5);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_memwrite", 32'(MemWrite), 32'd0);
        @(posedge clock); #1;
        chk("abort_state",   32'(state),   32'd0);
        chk("abort_irwrite", 32'(IRWrite), 32'd0);
        chk("abort_pcwrite", 32'(PCWrite), 32'd0);
        chk("abort_retired", 32'(retired), 32'd0);
        reset = 1'b0;
        exp_ret = 16'd0;
        fz_model = 1'b0;

        model(32'hE0821003, 1'b0, fz_model, v);
        apply("post_abort_add", v);

`ifdef MC_MEM_WAIT_EN
        // FETCH stalls three cycles on mem_ready, then fires once.
        inst = 32'hE0821003;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("wait_state",   32'(state),   32'd0);
            chk("wait_irwrite", 32'(IRWrite), 32'd0);
            chk("wait_pcwrite", 32'(PCWrite), 32'd0);
            @(posedge clock); #1;
        end
        mem_ready = 1'b1;
        @(negedge clock);
        chk("ready_irwrite", 32'(IRWrite), 32'd1);
        chk("ready_pcwrite", 32'(PCWrite), 32'd1);
        @(posedge clock); #1;
        chk("ready_state", 32'(state), 32'd1);
        @(negedge clock);
        chk("ready_irwrite_off", 32'(IRWrite), 32'd0);
        k = 0;
        do begin
            @(posedge clock); #1;
            k++;
        end while (state != 4'd0 && k < 8);
        exp_ret = exp_ret + 16'd1;
        chk("wait_retired", 32'(retired), 32'(exp_ret));
`endif

        chk("rule_violations", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
